// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcode constants, reset PC default and the fetch FSM encoding.
package dlx_pkg;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: sign extension, jump/branch target adders and priority mux.
module next_pc_sel
  import dlx_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] imm26_i,
  input  logic        branch_z_i,
  input  logic        branch_nz_i,
  input  logic        jmp_i,
  input  logic        jmp_r_i,
  input  logic        rs1_zero_i,
  input  logic [31:0] rs1_val_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] link_addr_o
);
  logic [31:0] jmp_tgt;
  logic [31:0] br_tgt;
  logic        br_taken;

  assign link_addr_o = pc_i + 32'd4;
  assign jmp_tgt     = link_addr_o + {{6{imm26_i[25]}}, imm26_i};
  assign br_tgt      = link_addr_o + {{16{imm26_i[15]}}, imm26_i[15:0]};
  assign br_taken    = (branch_z_i && rs1_zero_i) || (branch_nz_i && !rs1_zero_i);

  // Register jump beats direct jump beats conditional branch; alignment applied to every target.
  always_comb begin
    next_pc_o = link_addr_o;
    if (jmp_r_i)       next_pc_o = rs1_val_i;
    else if (jmp_i)    next_pc_o = jmp_tgt;
    else if (br_taken) next_pc_o = br_tgt;
    next_pc_o = word_align(next_pc_o);
  end
endmodule

// File: rtl/fetch_unit.sv
// DLX instruction fetch stage: PC/instruction registers, memory handshake FSM and retire counter.
module fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        exec_done,
  input  logic        branch_z,
  input  logic        branch_nz,
  input  logic        jmp,
  input  logic        jmp_r,
  input  logic        rs1_zero,
  input  logic [31:0] rs1_val,
  output logic [31:0] retired
);
  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  retired_q;
  logic         req_q;
  logic         valid_q;
  logic [31:0]  next_pc_d;
  logic [31:0]  retired_d;

  next_pc_sel u_next_pc_sel (
    .pc_i        (pc_q),
    .imm26_i     (inst_q[25:0]),
    .branch_z_i  (branch_z),
    .branch_nz_i (branch_nz),
    .jmp_i       (jmp),
    .jmp_r_i     (jmp_r),
    .rs1_zero_i  (rs1_zero),
    .rs1_val_i   (rs1_val),
    .next_pc_o   (next_pc_d),
    .link_addr_o (link_addr)
  );

  assign retired_d = retired_q + 32'd1;

  // req/valid are registered alongside the state so the memory sees glitch-free controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc_q      <= next_pc_d;
            retired_q <= retired_d;
            valid_q   <= 1'b0;
            req_q     <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = word_align(pc_q);
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign retired    = retired_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the DLX core. It holds the program counter and fetches instruction words over a req/ack handshake to instruction memory. It presents each word on `inst`, where the control decoder directly downstream decodes it. It then takes the branch, jump and jump-register decisions back from the decoder and the datapath to select the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address; valid while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `inst`  out  32  registered instruction, driving the control decoder.
- `inst_valid`  out  1  `inst` is a live instruction awaiting execution.
- `pc`  out  32  address of `inst`.
- `link_addr`  out  32  `pc`+4, the value written to r31 by JAL/JALR.
- `exec_done`  in  1  datapath has completed `inst`; next-PC inputs are valid this cycle.
- `branch_z`, `branch_nz`, `jmp`, `jmp_r`  in  1 each  decoder outputs for `inst`.
- `rs1_zero`  in  1  busA == 0, used for BEQZ/BNEZ.
- `rs1_val`  in  32  busA, the JR/JALR target.
- `retired`  out  32  count of completed instructions.

## Operation
- FSM states:
  - `S_IDLE`: entered on reset; unconditionally moves to `S_FETCH` on the first clock after `rst_n` deasserts.
  - `S_FETCH`: `imem_req`=1, `imem_addr`={pc[31:2],2'b00}. When `imem_ack`=1: `inst`<=`imem_rdata`, go to `S_EXEC`.
  - `S_EXEC`: `inst_valid`=1, `imem_req`=0. When `exec_done`=1: `pc`<=next_pc, `retired`<=`retired`+1, go to `S_FETCH`.
- next_pc, with priority from highest to lowest:
  - `jmp_r`: {rs1_val[31:2],2'b00}.
  - `jmp`: pc+4+sext(inst[25:0]).
  - `branch_z` with `rs1_zero`=1, or `branch_nz` with `rs1_zero`=0: pc+4+sext(inst[15:0]).
  - Otherwise: pc+4.
  - All address arithmetic is modulo 2^32. Target bits [1:0] are always forced to 0.
- If several of `jmp_r`/`jmp`/`branch_*` are asserted together, the priority order above decides; no error is flagged.
- `imem_ack` outside `S_FETCH` is ignored. `exec_done` outside `S_EXEC` is ignored.
- `retired` wraps from 32'hFFFF_FFFF to 0.
- There is no delay slot. The instruction after a taken branch is never fetched.

## Timing
- Reset values: `pc`=RESET_PC; `inst`=0; `inst_valid`=0; `imem_req`=0; `retired`=0; state=`S_IDLE`.
- `imem_req` and `imem_addr` are decoded from registered state only and are glitch-free. `imem_addr` stays stable until ack.
- Ack may arrive in the first `S_FETCH` cycle. The minimum is one fetch cycle plus one exec cycle, i.e. 2 cycles per instruction.
- `inst`, `pc` and `link_addr` are stable for the whole of `S_EXEC`.
- Reset asserted mid-fetch: the outstanding request is abandoned. Instruction memory must tolerate `imem_req` dropping without an ack.
- `exec_done` and `imem_ack` can never be sampled in the same state, so there is no simultaneous-event case.

## Structure
- Shared package `dlx_pkg`: opcode constants (J=6'h02, JAL=6'h03, BEQZ=6'h04, BNEZ=6'h05, JR=6'h12, JALR=6'h13), `RESET_PC` default, and the FSM state enum.
- Sub-module `next_pc_sel`: purely combinational. It holds the sign extension, the two target adders and the priority mux.
- `fetch_unit` keeps the FSM, the `pc`/`inst`/`retired` registers and the handshake logic.

## Test plan
- Reset and first fetch: release `rst_n` with RESET_PC=0. Expect `imem_req`=1 with `imem_addr`=0 on the 2nd edge. Ack with 32'h2001_0005 → `inst`=32'h2001_0005, `inst_valid`=1, `link_addr`=4.
- Sequential flow with slow memory: ack after 3 wait cycles. `imem_addr` must stay constant throughout; after `exec_done`, next `imem_addr`=pc+4.
- Branches at pc=32'h100 with imm=16'hFFF0:
  - BEQZ with `rs1_zero`=1 → next pc 32'h0F4.
  - BEQZ with `rs1_zero`=0 → 32'h104.
  - BNEZ with `rs1_zero`=0 → 32'h0F4.
- Jumps:
  - J at pc=32'hFFFF_FFFC with offset 4 → wraps to 32'h4.
  - JR with `rs1_val`=32'h1237 → 32'h1234.
  - `jmp_r` and `branch_z` both asserted → the JR target is taken.
- Reset mid-operation: assert `rst_n`=0 during `S_FETCH` and during `S_EXEC`. All outputs must return to reset values immediately, without a clock edge; `retired` returns to 0.
- Counter: run 5 instructions → `retired`=5. Preload `retired` to 32'hFFFF_FFFF via force, complete one instruction → 0.
